// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle,
// then a single fix-up cycle applies sign correction and writes HI/LO.
// Optional build macro MULDIV_EARLY_EXIT_EN: a zero divisor/multiplier skips
// the iteration phase (IDLE -> FIX -> IDLE); results are the same either way.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Two's-complement negate when en is set (single word).
  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  // Two's-complement negate when en is set (double word product).
  function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  // Magnitude of a signed operand; the most negative value maps to itself
  // as an unsigned bit pattern, which is the correct magnitude.
  function automatic logic [WIDTH-1:0] f_abs(input logic signed [WIDTH-1:0] v);
    return f_neg(v, v[WIDTH-1]);
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Operand/iteration datapath (no reset needed; always loaded before use).
  logic             r_is_div;
  logic             r_signed;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;

  logic             w_load;
  logic             w_step;
  logic             w_fix;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic                    w_op_signed;
  logic [WIDTH-1:0]        w_mag_a;
  logic [WIDTH-1:0]        w_mag_b;

  logic [WIDTH:0]          w_mul_sum;
  logic [WIDTH:0]          w_div_sh;
  logic [WIDTH:0]          w_div_diff;

  logic [2*WIDTH-1:0]      w_prod_fix;
  logic                    w_div_zero;
  logic [WIDTH-1:0]        w_fix_hi;
  logic [WIDTH-1:0]        w_fix_lo;

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Operand conditioning at launch: MULT/DIV (op[0]==0) use magnitudes.
  assign w_a_s       = signed'(a);
  assign w_b_s       = signed'(b);
  assign w_op_signed = ~op[0];
  assign w_mag_a     = w_op_signed ? f_abs(w_a_s) : a;
  assign w_mag_b     = w_op_signed ? f_abs(w_b_s) : b;

  // One iteration step: multiply adds the multiplicand when the multiplier
  // LSB is set; divide tries a subtract of the divisor from the shifted remainder.
  assign w_mul_sum  = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_opa} : '0);
  assign w_div_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_opb};

  // Fix-up results: sign correction, and the divide-by-zero override that
  // returns the original dividend in HI and all ones in LO.
  assign w_prod_fix = f_neg2({r_rem, r_quo}, r_signed & (r_sa ^ r_sb));
  assign w_div_zero = (r_opb == '0);
  assign w_fix_hi   = r_is_div ? (w_div_zero ? f_neg(r_opa, r_sa) : f_neg(r_rem, r_sa))
                               : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_fix_lo   = r_is_div ? (w_div_zero ? '1 : f_neg(r_quo, r_sa ^ r_sb))
                               : w_prod_fix[WIDTH-1:0];

  // Next-state and control strobes for the IDLE -> CALC -> FIX sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_CALC;
`ifdef MULDIV_EARLY_EXIT_EN
          if (b == '0) w_state_nxt = S_FIX;
`endif
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Control and architectural HI/LO: busy/done flags, step counter, FIX and MTHI/MTLO writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_load)      r_cnt <= CW'(WIDTH);
      else if (w_step) r_cnt <= r_cnt - CW'(1);
      if (w_fix) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else if (r_state == S_IDLE && !start) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
    end
  end

  // Operand latch at launch, then one multiply or divide step per CALC cycle.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_is_div <= op[1];
      r_signed <= w_op_signed;
      r_sa     <= w_op_signed & a[WIDTH-1];
      r_sb     <= w_op_signed & b[WIDTH-1];
      r_opa    <= w_mag_a;
      r_opb    <= w_mag_b;
      r_rem    <= '0;
      r_quo    <= op[1] ? w_mag_a : w_mag_b;
    end else if (w_step) begin
      if (r_is_div) begin
        if (!w_div_diff[WIDTH]) begin
          r_rem <= w_div_diff[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b1};
        end else begin
          r_rem <= w_div_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b0};
        end
      end else begin
        {r_rem, r_quo} <= {w_mul_sum, r_quo[WIDTH-1:1]};
      end
    end
  end

endmodule
